// File: rtl/spi_target_pkg.sv
// spi_target_pkg: opcodes, FSM state encoding and synchronizer depth shared by
// the SPI target register file and its pin synchronizer.
package spi_target_pkg;

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_RDSR  = 8'h05;

  // Flip-flops between an SPI pin and the edge-detect register.
  localparam int SYNC_DEPTH = 2;

  // ST_RDSR is only reachable when SPI_TARGET_STATUS_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_WDATA  = 3'd3,
    ST_RDATA  = 3'd4,
    ST_IGNORE = 3'd5,
    ST_RDSR   = 3'd6
  } spi_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: SYNC_DEPTH-stage synchronizer for one asynchronous SPI pin,
// followed by a single history register that yields rise/fall pulses.
// All stages reset to 0, so a pin already low at reset release never
// produces a spurious falling edge.
module spi_pin_sync
  import spi_target_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_DEPTH-1:0] r_sync;
  logic                  r_prev;

  // Shift the raw pin through the synchronizer and keep one cycle of history
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_DEPTH-2:0], i_pin};
      r_prev <= r_sync[SYNC_DEPTH-1];
    end
  end

  assign o_level = r_sync[SYNC_DEPTH-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/spi_target_regfile.sv
// spi_target_regfile: SPI target with a 2^ADDR_W byte register file decoding
// WRITE (0x02) / READ (0x03) command frames, oversampled in the i_aclk domain.
// Optional feature macro: SPI_TARGET_STATUS_EN adds opcode 0x05 (RDSR) that
// returns the number of completed write frames modulo 256.
module spi_target_regfile
  import spi_target_pkg::*;
#(
  parameter int CPOL   = 0,
  parameter int CPHA   = 0,
  parameter int ADDR_W = 4
) (
  input  logic              i_aclk,
  input  logic              i_aresetn,
  input  logic              i_spi_sck,
  input  logic              i_spi_mosi,
  input  logic              i_spi_cs,
  output logic              o_spi_miso,
  output logic              o_spi_miso_oe,
  output logic              o_wr_strobe,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  // Pin index 0 = SCK, 1 = MOSI, 2 = CS.
  logic [2:0] w_pin_in;
  logic [2:0] w_pin_lvl;
  logic [2:0] w_pin_rise;
  logic [2:0] w_pin_fall;

  assign w_pin_in = {i_spi_cs, i_spi_mosi, i_spi_sck};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_pin_sync
      spi_pin_sync u_pin_sync (
        .i_clk   (i_aclk),
        .i_rst_n (i_aresetn),
        .i_pin   (w_pin_in[gi]),
        .o_level (w_pin_lvl[gi]),
        .o_rise  (w_pin_rise[gi]),
        .o_fall  (w_pin_fall[gi])
      );
    end
  endgenerate

  // SCK level and MOSI edges carry no information for this protocol.
  logic w_unused_pins;
  assign w_unused_pins = ^{w_pin_lvl[0], w_pin_rise[1], w_pin_fall[1]};

  logic w_lead;
  logic w_trail;
  logic w_sample;
  logic w_shift;
  logic w_cs_fall;
  logic w_cs_rise;
  logic w_cs_lvl;
  logic w_mosi;

  // Leading edge is rising for CPOL=0; CPHA picks which edge samples MOSI.
  assign w_lead    = (CPOL == 0) ? w_pin_rise[0] : w_pin_fall[0];
  assign w_trail   = (CPOL == 0) ? w_pin_fall[0] : w_pin_rise[0];
  assign w_sample  = (CPHA == 0) ? w_lead  : w_trail;
  assign w_shift   = (CPHA == 0) ? w_trail : w_lead;
  assign w_cs_fall = w_pin_fall[2];
  assign w_cs_rise = w_pin_rise[2];
  assign w_cs_lvl  = w_pin_lvl[2];
  assign w_mosi    = w_pin_lvl[1];

  spi_state_t        r_state;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_rx;
  logic [7:0]        r_tx;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rd_dir;
  logic              r_miso_bit;
  logic              r_wr_pulse;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic [7:0]        r_mem [DEPTH];

  logic              r_out_strobe;
  logic              r_out_miso;
  logic              r_armed;
  logic              r_busy;

  logic [7:0]        w_rx_byte;
  logic              w_byte_done;
  logic              w_tx_active;
  logic [ADDR_W-1:0] w_addr_field;

  assign w_rx_byte    = {r_rx[6:0], w_mosi};
  assign w_byte_done  = w_sample && (r_bit_cnt == 3'd7);
  assign w_tx_active  = (r_state == ST_RDATA) || (r_state == ST_RDSR);
  assign w_addr_field = w_rx_byte[ADDR_W-1:0];

`ifdef SPI_TARGET_STATUS_EN
  logic [7:0] r_frame_cnt;
  logic       r_frame_wrote;

  // Count write frames that committed at least one data byte before CS rose
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_frame_cnt   <= 8'd0;
      r_frame_wrote <= 1'b0;
    end else begin
      if (w_cs_fall) begin
        r_frame_wrote <= 1'b0;
      end else if (r_wr_pulse) begin
        r_frame_wrote <= 1'b1;
      end
      if (w_cs_rise && r_frame_wrote) begin
        r_frame_cnt   <= r_frame_cnt + 8'd1;
        r_frame_wrote <= 1'b0;
      end
    end
  end
`endif

  // Command FSM with serial shift registers, register file and write capture
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_rx       <= 8'd0;
      r_tx       <= 8'd0;
      r_addr     <= '0;
      r_rd_dir   <= 1'b0;
      r_miso_bit <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'd0;
      end
    end else begin
      r_wr_pulse <= 1'b0;
      if (w_cs_rise) begin
        // Frame end: any partial byte is simply dropped.
        r_state    <= ST_IDLE;
        r_miso_bit <= 1'b0;
      end else begin
        if (w_sample && (r_state != ST_IDLE)) begin
          r_rx      <= w_rx_byte;
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        if (w_shift && (r_state != ST_IDLE)) begin
          if (w_tx_active) begin
            r_miso_bit <= r_tx[7];
            r_tx       <= {r_tx[6:0], 1'b0};
          end else begin
            r_miso_bit <= 1'b0;
          end
        end
        case (r_state)
          ST_IDLE: begin
            // A falling edge implies CS was seen high since reset.
            if (w_cs_fall) begin
              r_state    <= ST_CMD;
              r_bit_cnt  <= 3'd0;
              r_miso_bit <= 1'b0;
            end
          end
          ST_CMD: begin
            if (w_byte_done) begin
              case (w_rx_byte)
                OP_WRITE: begin
                  r_state  <= ST_ADDR;
                  r_rd_dir <= 1'b0;
                end
                OP_READ: begin
                  r_state  <= ST_ADDR;
                  r_rd_dir <= 1'b1;
                end
`ifdef SPI_TARGET_STATUS_EN
                OP_RDSR: begin
                  r_state <= ST_RDSR;
                  r_tx    <= r_frame_cnt;
                end
`endif
                default: r_state <= ST_IGNORE;
              endcase
            end
          end
          ST_ADDR: begin
            if (w_byte_done) begin
              if (r_rd_dir) begin
                r_tx    <= r_mem[w_addr_field];
                r_addr  <= w_addr_field + ADDR_ONE;
                r_state <= ST_RDATA;
              end else begin
                r_addr  <= w_addr_field;
                r_state <= ST_WDATA;
              end
            end
          end
          ST_WDATA: begin
            if (w_byte_done) begin
              r_mem[r_addr] <= w_rx_byte;
              r_wr_pulse    <= 1'b1;
              r_wr_addr     <= r_addr;
              r_wr_data     <= w_rx_byte;
              r_addr        <= r_addr + ADDR_ONE;
            end
          end
          ST_RDATA: begin
            if (w_byte_done) begin
              r_tx   <= r_mem[r_addr];
              r_addr <= r_addr + ADDR_ONE;
            end
          end
`ifdef SPI_TARGET_STATUS_EN
          ST_RDSR: begin
            if (w_byte_done) begin
              r_tx <= r_frame_cnt;
            end
          end
`endif
          ST_IGNORE: begin
            r_state <= ST_IGNORE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Output stage: strobe and MISO registered once more, busy tracks CS
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_out_strobe <= 1'b0;
      r_out_miso   <= 1'b0;
      r_armed      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_out_strobe <= r_wr_pulse;
      r_out_miso   <= r_miso_bit;
      if (w_cs_lvl) begin
        r_armed <= 1'b1;
      end
      r_busy <= r_armed & ~w_cs_lvl;
    end
  end

  assign o_spi_miso    = r_out_miso;
  assign o_spi_miso_oe = r_busy;
  assign o_busy        = r_busy;
  assign o_wr_strobe   = r_out_strobe;
  assign o_wr_addr     = r_wr_addr;
  assign o_wr_data     = r_wr_data;

endmodule
